fu_issue_ctrl: RTL and testbench

- Issue controller in front of the functional unit (ALU, barrel shifter, MADD).
- Accepts one operation at a time over a valid/ready request handshake and drives registered operands plus a one-hot unit enable into the datapath.
- Waits the class-specific latency, captures Z, and presents it over a valid/ready result handshake.
- Replaces ad-hoc clock gating with synchronous enables and provides back-pressure.

---
 rtl/fu_pkg.sv | 32 +++
 rtl/fu_lat_counter.sv | 34 +++
 rtl/fu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fu_issue_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared constants for the FU issue path: request classes, enable bit positions, FSM states.
// Latency: n/a; backpressure: n/a.
package fu_pkg;

    localparam logic [1:0] CLS_ALU   = 2'd0;
    localparam logic [1:0] CLS_SHIFT = 2'd1;
    localparam logic [1:0] CLS_MADD  = 2'd2;
    localparam logic [1:0] CLS_RSVD  = 2'd3;

    localparam int EN_ALU_BIT  = 2;
    localparam int EN_BS_BIT   = 1;
    localparam int EN_MADD_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [2:0] class_en(input logic [1:0] cls);
        logic [2:0] en;
        en = 3'b000;
        case (cls)
            CLS_ALU:   en[EN_ALU_BIT]  = 1'b1;
            CLS_SHIFT: en[EN_BS_BIT]   = 1'b1;
            CLS_MADD:  en[EN_MADD_BIT] = 1'b1;
            default:   en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/fu_lat_counter.sv
// 4-bit down-counter timing the functional-unit latency; zero flag is registered-state based.
// Latency: load/decrement visible next cycle; backpressure: none, driven by the issue FSM.
module fu_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/fu_issue_ctrl.sv
// Issues one op at a time to ALU/shifter/MADD, waits the class latency and holds the result.
// Latency: LAT+1 cycles accept-to-result; backpressure: REQ_READY low in EXEC and in DONE until RES_READY.
module fu_issue_ctrl
    import fu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ALU_LAT  = 1,
    parameter int BS_LAT   = 1,
    parameter int MADD_LAT = 3
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_CLASS,
    input  logic [3:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    input  logic [WIDTH-1:0] REQ_C,
    input  logic             REQ_CI,
    output logic [WIDTH-1:0] FU_A,
    output logic [WIDTH-1:0] FU_B,
    output logic [WIDTH-1:0] FU_C,
    output logic [3:0]       FU_OP,
    output logic             FU_CI,
    output logic [2:0]       FU_EN,
    input  logic [WIDTH-1:0] FU_Z,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_Z,
    output logic             RES_ERR,
    output logic             BUSY
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d, fu_c_q, fu_c_d;
    logic [WIDTH-1:0] res_z_q, res_z_d;
    logic [3:0]       fu_op_q, fu_op_d;
    logic             fu_ci_q, fu_ci_d;
    logic [2:0]       fu_en_q, fu_en_d;
    logic             res_err_q, res_err_d;

    logic       req_rdy;
    logic       accept;
    logic       cnt_zero;
    logic [3:0] lat_ld;

    assign accept = REQ_VALID && req_rdy;

    always_comb begin
        case (REQ_CLASS)
            CLS_ALU:   lat_ld = 4'(ALU_LAT - 1);
            CLS_SHIFT: lat_ld = 4'(BS_LAT - 1);
            CLS_MADD:  lat_ld = 4'(MADD_LAT - 1);
            default:   lat_ld = 4'd0;
        endcase
    end

    fu_lat_counter u_lat_counter (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .load     (accept),
        .load_val (lat_ld),
        .dec      (state_q == ST_EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_d = (REQ_CLASS == CLS_RSVD) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new request in the handshake cycle skips IDLE entirely.
                if (RES_READY) begin
                    if (REQ_VALID) begin
                        state_d = (REQ_CLASS == CLS_RSVD) ? ST_DONE : ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && RES_READY);
        RES_VALID = (state_q == ST_DONE);
        BUSY      = (state_q != ST_IDLE);
    end

    always_comb begin
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        fu_c_d    = fu_c_q;
        fu_op_d   = fu_op_q;
        fu_ci_d   = fu_ci_q;
        fu_en_d   = fu_en_q;
        res_z_d   = res_z_q;
        res_err_d = res_err_q;
        if (accept) begin
            fu_a_d  = REQ_A;
            fu_b_d  = REQ_B;
            fu_c_d  = REQ_C;
            fu_op_d = REQ_OP;
            fu_ci_d = REQ_CI;
            fu_en_d = class_en(REQ_CLASS);
            if (REQ_CLASS == CLS_RSVD) begin
                res_z_d   = '0;
                res_err_d = 1'b1;
            end
        end else if ((state_q == ST_EXEC) && cnt_zero) begin
            res_z_d   = FU_Z;
            res_err_d = 1'b0;
            fu_en_d   = 3'b000;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            fu_c_q    <= '0;
            fu_op_q   <= 4'd0;
            fu_ci_q   <= 1'b0;
            fu_en_q   <= 3'b000;
            res_z_q   <= '0;
            res_err_q <= 1'b0;
        end else begin
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            fu_c_q    <= fu_c_d;
            fu_op_q   <= fu_op_d;
            fu_ci_q   <= fu_ci_d;
            fu_en_q   <= fu_en_d;
            res_z_q   <= res_z_d;
            res_err_q <= res_err_d;
        end
    end

    assign REQ_READY = req_rdy;
    assign FU_A      = fu_a_q;
    assign FU_B      = fu_b_q;
    assign FU_C      = fu_c_q;
    assign FU_OP     = fu_op_q;
    assign FU_CI     = fu_ci_q;
    assign FU_EN     = fu_en_q;
    assign RES_Z     = res_z_q;
    assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl with a behavioural datapath model on FU_Z.
module tb_fu_issue_ctrl;

    localparam int WIDTH = 32;

    logic             CLOCK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             REQ_VALID = 1'b0;
    logic             REQ_READY;
    logic [1:0]       REQ_CLASS = 2'd0;
    logic [3:0]       REQ_OP = 4'd0;
    logic [WIDTH-1:0] REQ_A = '0, REQ_B = '0, REQ_C = '0;
    logic             REQ_CI = 1'b0;
    logic [WIDTH-1:0] FU_A, FU_B, FU_C;
    logic [3:0]       FU_OP;
    logic             FU_CI;
    logic [2:0]       FU_EN;
    logic [WIDTH-1:0] FU_Z;
    logic             RES_VALID;
    logic             RES_READY = 1'b0;
    logic [WIDTH-1:0] RES_Z;
    logic             RES_ERR;
    logic             BUSY;

    int n_vec  = 0;
    int n_miss = 0;

    fu_issue_ctrl #(.WIDTH(WIDTH), .ALU_LAT(1), .BS_LAT(1), .MADD_LAT(3)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CLASS(REQ_CLASS), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C), .REQ_CI(REQ_CI),
        .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C), .FU_OP(FU_OP), .FU_CI(FU_CI), .FU_EN(FU_EN),
        .FU_Z(FU_Z), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_Z(RES_Z),
        .RES_ERR(RES_ERR), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Datapath stand-in: add-with-carry, left shift, multiply-add.
    always_comb begin
        FU_Z = '0;
        if (FU_EN[2])      FU_Z = FU_A + FU_B + {{(WIDTH-1){1'b0}}, FU_CI};
        else if (FU_EN[1]) FU_Z = FU_A << FU_B[4:0];
        else if (FU_EN[0]) FU_Z = FU_A * FU_B + FU_C;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] cls, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic ci);
        REQ_VALID = 1'b1;
        REQ_CLASS = cls;
        REQ_A     = a;
        REQ_B     = b;
        REQ_C     = c;
        REQ_CI    = ci;
        REQ_OP    = 4'h3;
    endtask

    initial begin
        int seen_vld;

        // Reset state
        #3;
        chk("rst_fu_en", 32'(FU_EN), 32'd0);
        chk("rst_res_vld", 32'(RES_VALID), 32'd0);
        chk("rst_res_z", RES_Z, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_fu_a", FU_A, 32'd0);
        chk("rst_req_rdy", 32'(REQ_READY), 32'd1);
        tick();
        RESET_N = 1'b1;
        tick();

        // ALU 5+7, LAT=1, consumer ready
        RES_READY = 1'b1;
        drive_req(2'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        #1;
        chk("alu_req_rdy_idle", 32'(REQ_READY), 32'd1);
        tick();
        REQ_VALID = 1'b0;
        chk("alu_fu_en", 32'(FU_EN), 32'b100);
        chk("alu_fu_op", 32'(FU_OP), 32'h3);
        chk("alu_req_rdy_exec", 32'(REQ_READY), 32'd0);
        chk("alu_vld_c1", 32'(RES_VALID), 32'd0);
        tick();
        chk("alu_vld_c2", 32'(RES_VALID), 32'd1);
        chk("alu_res_z", RES_Z, 32'd12);
        chk("alu_fu_en_off", 32'(FU_EN), 32'd0);
        tick();
        chk("alu_vld_clr", 32'(RES_VALID), 32'd0);
        chk("alu_busy_idle", 32'(BUSY), 32'd0);

        // MADD 3*4+5, LAT=3, consumer stalled
        RES_READY = 1'b0;
        drive_req(2'd2, 32'd3, 32'd4, 32'd5, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        REQ_A     = 32'd99;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("madd_fu_en_c%0d", i), 32'(FU_EN), 32'b001);
            chk($sformatf("madd_req_rdy_c%0d", i), 32'(REQ_READY), 32'd0);
            chk($sformatf("madd_fu_a_c%0d", i), FU_A, 32'd3);
            chk($sformatf("madd_vld_c%0d", i), 32'(RES_VALID), 32'd0);
            tick();
        end
        chk("madd_vld", 32'(RES_VALID), 32'd1);
        chk("madd_res_z", RES_Z, 32'd17);
        chk("madd_res_err", 32'(RES_ERR), 32'd0);
        chk("madd_fu_en_off", 32'(FU_EN), 32'd0);

        // Hold-off with a pending shift request 1<<4
        drive_req(2'd1, 32'd1, 32'd4, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_vld_%0d", i), 32'(RES_VALID), 32'd1);
            chk($sformatf("stall_z_%0d", i), RES_Z, 32'd17);
            chk($sformatf("stall_req_rdy_%0d", i), 32'(REQ_READY), 32'd0);
        end
        RES_READY = 1'b1;
        #1;
        chk("release_req_rdy", 32'(REQ_READY), 32'd1);
        tick();
        REQ_VALID = 1'b0;
        RES_READY = 1'b0;
        chk("b2b_busy", 32'(BUSY), 32'd1);
        chk("b2b_fu_en", 32'(FU_EN), 32'b010);
        chk("b2b_vld_clr", 32'(RES_VALID), 32'd0);
        tick();
        chk("bs_vld", 32'(RES_VALID), 32'd1);
        chk("bs_res_z", RES_Z, 32'd16);

        // Back-to-back into a reserved-class request
        RES_READY = 1'b1;
        drive_req(2'd3, 32'd8, 32'd9, 32'd1, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        chk("rsvd_vld", 32'(RES_VALID), 32'd1);
        chk("rsvd_err", 32'(RES_ERR), 32'd1);
        chk("rsvd_z", RES_Z, 32'd0);
        chk("rsvd_fu_en", 32'(FU_EN), 32'd0);
        chk("rsvd_busy", 32'(BUSY), 32'd1);
        tick();
        chk("rsvd_done_idle", 32'(BUSY), 32'd0);

        // Reserved class from IDLE
        drive_req(2'd3, 32'd1, 32'd1, 32'd1, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        chk("rsvd2_vld", 32'(RES_VALID), 32'd1);
        chk("rsvd2_err", 32'(RES_ERR), 32'd1);
        tick();

        // Reset mid-MADD
        drive_req(2'd2, 32'd2, 32'd3, 32'd1, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        RESET_N = 1'b0;
        #1;
        chk("arst_fu_en", 32'(FU_EN), 32'd0);
        chk("arst_fu_a", FU_A, 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_vld", 32'(RES_VALID), 32'd0);
        tick();
        RESET_N = 1'b1;
        seen_vld = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RES_VALID) seen_vld++;
        end
        chk("arst_no_result", 32'(seen_vld), 32'd0);

        // Normal ALU after reset: 10+20+ci
        drive_req(2'd0, 32'd10, 32'd20, 32'd0, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        chk("post_fu_en", 32'(FU_EN), 32'b100);
        tick();
        chk("post_vld", 32'(RES_VALID), 32'd1);
        chk("post_res_z", RES_Z, 32'd31);
        tick();
        chk("post_idle", 32'(BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
